tb_vector_sequencer: RTL and testbench
======================================

Name: tb_vector_sequencer

Overview:
- Testbench-side controller that runs a stored vector set through a DUT and the vector comparator.
- Reads stimulus/expected pairs from a synchronous vector memory and drives stimulus into the DUT.
- Generates the comparator's cmp_on/ctrans/exp_vec_out with correct alignment, then issues a pass/fail verdict from comparator counter deltas.
- Sits between vector memory, DUT and comparator in the standard bench top.

Parameters:
IN_WIDTH, 8, DUT stimulus width
EXP_WIDTH, 8, expected vector width (matches comparator EXP_DATA_OUT_WIDTH)
ADDR_WIDTH, 8, vector memory address width; also width of num_vec
CNT_WIDTH, 16, comparator counter width
DUT_LAT, 2, cycles from dut_in_valid to corresponding DUT output valid; legal range 1..8

Ports:
clk  in  1  bench clock
reset  in  1  synchronous, active-high reset
start  in  1  run request; accepted only in IDLE
num_vec  in  ADDR_WIDTH  vectors to run; sampled with accepted start
hold  in  1  stall new vector issue
mem_addr  out  ADDR_WIDTH  vector memory address
mem_rd  out  1  memory read strobe; data valid next cycle
mem_stim  in  IN_WIDTH  stimulus read data
mem_exp  in  EXP_WIDTH  expected read data
dut_in_vec  out  IN_WIDTH  DUT stimulus
dut_in_valid  out  1  stimulus valid
cmp_on  out  1  comparator enable window
ctrans  out  1  comparator transaction strobe
exp_vec_out  out  EXP_WIDTH  expected vector to comparator
match_cnt  in  CNT_WIDTH  comparator match counter
miss_cnt  in  CNT_WIDTH  comparator miss counter
busy  out  1  run in progress
done  out  1  one-cycle end-of-run pulse
pass  out  1  verdict; valid from done until next accepted start

Behaviour:
- Reset: state IDLE, pipeline emptied, all outputs 0. Reset mid-run aborts immediately with no done pulse. Comparator counters are not touched.

State machine:
- IDLE: start=1 latches num_vec, base_match=match_cnt, base_miss=miss_cnt; clears pass; sets issue index to 0.
  - num_vec=0 goes to CHECK.
  - Otherwise goes to RUN.
- RUN: each cycle with hold=0 and index<num_vec, assert mem_rd with mem_addr=index and increment index.
  - After last issue, go to DRAIN.
  - hold=1 suppresses mem_rd only; in-flight vectors keep advancing.
- DRAIN: wait until the pipeline is empty, then 2 further cycles for comparator enable delay plus counter update, then go to CHECK.
- CHECK (1 cycle):
  - dm = match_cnt-base_match, dx = miss_cnt-base_miss, both mod 2^CNT_WIDTH.
  - pass = (dx==0) && (dm==num_vec).
  - Go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.

Timing relative to a read in cycle t:
- t+1: dut_in_vec=mem_stim, dut_in_valid=1; mem_exp enters a valid/data delay pipe.
- t+1+DUT_LAT: ctrans=1.
- t+2+DUT_LAT: exp_vec_out holds that vector's expected value. This satisfies the comparator's one-cycle internal delay.
- exp_vec_out holds its last value when no transaction is in flight.

Other signals and rules:
- Throughput: one vector per cycle with hold=0; back-to-back ctrans allowed.
- cmp_on=1 from the cycle after start acceptance through the last DRAIN cycle.
- busy=1 in every state except IDLE.
- dut_in_valid=0 and ctrans=0 when nothing is in flight.
- start while busy: ignored.
- num_vec = 2^ADDR_WIDTH-1: addresses 0..num_vec-1; index never wraps.

Optional Feature:
SEQ_STOP_ON_MISS_EN
- Defined: in RUN, if miss_cnt != base_miss, stop issuing and go to DRAIN. In-flight vectors still complete, and pass=0.
- Undefined: all num_vec vectors always run; misses affect only the final verdict.

Test Plan:
- DUT_LAT=2, echo DUT (exp=stim), num_vec=4, start at cycle c:
  - mem_rd at c+1..c+4, addrs 0..3.
  - ctrans at c+4..c+7.
  - done at c+13, pass=1.
  - Comparator deltas: match=4, miss=0.
- Same setup, mem_exp[2] corrupted -> done with pass=0; dm=3, dx=1.
- hold=1 for 3 cycles after the second issue -> mem_rd gap of 3 cycles; ctrans shows the same 3-cycle gap; pass=1.
- num_vec=0 -> no mem_rd, no ctrans; done 2 cycles after start, pass=1.
- Comparator counters preloaded to 0xFFFE, num_vec=4, all match -> wrap-around delta=4, pass=1.
- reset asserted mid-RUN after 2 issues -> next cycle all outputs 0, state IDLE, no done; a new start runs a full set correctly.

Source files
------------

// File: rtl/tb_vector_sequencer.sv
// tb_vector_sequencer: streams stored stimulus/expected vectors through DUT and comparator.
// Optional `SEQ_STOP_ON_MISS_EN: stop issuing new vectors on the first comparator miss.
module tb_vector_sequencer #(
  parameter int IN_WIDTH   = 8,
  parameter int EXP_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int DUT_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_vec,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [IN_WIDTH-1:0]   mem_stim,
  input  logic [EXP_WIDTH-1:0]  mem_exp,
  output logic [IN_WIDTH-1:0]   dut_in_vec,
  output logic                  dut_in_valid,
  output logic                  cmp_on,
  output logic                  ctrans,
  output logic [EXP_WIDTH-1:0]  exp_vec_out,
  input  logic [CNT_WIDTH-1:0]  match_cnt,
  input  logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, CHECK, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0]  base_match;
  logic [CNT_WIDTH-1:0]  base_miss;
  logic [1:0]            wait_q;
  logic                  rd_q;
  logic [DUT_LAT-1:0]    v_q;
  logic                  x_q;
  logic [EXP_WIDTH-1:0]  e_q [DUT_LAT];
  logic                  stop;
  logic                  last;
  logic                  pipe_empty;
  logic [CNT_WIDTH-1:0]  dm;
  logic [CNT_WIDTH-1:0]  dx;

`ifdef SEQ_STOP_ON_MISS_EN
  assign stop = (miss_cnt != base_miss);
`else
  assign stop = 1'b0;
`endif

  assign mem_rd = (state == RUN) && !hold
                  && !stop && (idx < n_q);
  assign mem_addr = mem_rd ? idx : '0;
  assign last = mem_rd && (idx == n_q - 1'b1);

  assign dut_in_valid = rd_q;
  assign dut_in_vec = rd_q ? mem_stim : '0;
  assign ctrans = v_q[DUT_LAT-1];
  assign pipe_empty = !rd_q && !(|v_q) && !x_q;

  assign busy = (state != IDLE);
  assign cmp_on = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  assign dm = match_cnt - base_match;
  assign dx = miss_cnt - base_miss;

  // Valid pipe: read strobe -> stimulus -> DUT latency -> exp_vec_out stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0;
      v_q <= '0;
      x_q <= 1'b0;
      exp_vec_out <= '0;
    end else begin
      rd_q <= mem_rd;
      v_q[0] <= rd_q;
      for (int i = 1; i < DUT_LAT; i++)
        v_q[i] <= v_q[i-1];
      x_q <= v_q[DUT_LAT-1];
      if (v_q[DUT_LAT-1])
        exp_vec_out <= e_q[DUT_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    e_q[0] <= mem_exp;
    for (int i = 1; i < DUT_LAT; i++)
      e_q[i] <= e_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n_q <= '0;
      idx <= '0;
      base_match <= '0;
      base_miss <= '0;
      wait_q <= '0;
      pass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q <= num_vec;
            base_match <= match_cnt;
            base_miss <= miss_cnt;
            pass <= 1'b0;
            idx <= '0;
            state <= (num_vec == '0) ? CHECK : RUN;
          end
        end
        RUN: begin
          wait_q <= '0;
          if (mem_rd)
            idx <= idx + 1'b1;
          if (stop || last)
            state <= DRAIN;
        end
        DRAIN: begin
          // two extra cycles: comparator enable delay plus counter update
          if (!pipe_empty)
            wait_q <= '0;
          else if (wait_q == 2'd2)
            state <= CHECK;
          else
            wait_q <= wait_q + 2'd1;
        end
        CHECK: begin
          pass <= (dx == '0) && (dm == CNT_WIDTH'(n_q));
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_vector_sequencer.sv
// Bench for tb_vector_sequencer: echo DUT, comparator and vector memory models,
// with directed and randomized runs checked against a cycle-level reference model.
module tb_tb_vector_sequencer;

  localparam int LAT = 2;
  localparam int HP  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_vec;
  logic        hold;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_stim;
  logic [7:0]  mem_exp;
  logic [7:0]  dut_in_vec;
  logic        dut_in_valid;
  logic        cmp_on;
  logic        ctrans;
  logic [7:0]  exp_vec_out;
  logic [15:0] match_c;
  logic [15:0] miss_c;
  logic        busy;
  logic        done;
  logic        pass;

  logic [7:0]  stim_mem [256];
  logic [7:0]  exp_mem [256];
  logic        hold_pat [HP];
  logic [7:0]  dpipe [LAT];
  logic [7:0]  dut_d;
  logic        ct_d = 1'b0;
  logic        preload_en = 1'b0;
  logic [15:0] preload_val = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tb_vector_sequencer #(
    .IN_WIDTH(8), .EXP_WIDTH(8), .ADDR_WIDTH(8),
    .CNT_WIDTH(16), .DUT_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_vec(num_vec), .hold(hold),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_stim(mem_stim), .mem_exp(mem_exp),
    .dut_in_vec(dut_in_vec), .dut_in_valid(dut_in_valid),
    .cmp_on(cmp_on), .ctrans(ctrans),
    .exp_vec_out(exp_vec_out),
    .match_cnt(match_c), .miss_cnt(miss_c),
    .busy(busy), .done(done), .pass(pass)
  );

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_stim <= stim_mem[mem_addr];
      mem_exp <= exp_mem[mem_addr];
    end
  end

  // echo DUT with LAT cycles of latency
  always @(posedge clk) begin
    dpipe[0] <= dut_in_vec;
    for (int i = 1; i < LAT; i++)
      dpipe[i] <= dpipe[i-1];
  end

  // comparator: expected value arrives one cycle after ctrans
  always @(posedge clk) begin
    ct_d <= reset ? 1'b0 : (ctrans & cmp_on);
    dut_d <= dpipe[LAT-1];
    if (preload_en) begin
      match_c <= preload_val;
      miss_c <= preload_val;
    end else if (ct_d) begin
      if (exp_vec_out == dut_d)
        match_c <= match_c + 16'd1;
      else
        miss_c <= miss_c + 16'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic preload(input logic [15:0] v);
    @(posedge clk); #1;
    preload_en = 1'b1;
    preload_val = v;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  task automatic load_mem(input int n, input int bad_pct);
    for (int i = 0; i < n; i++) begin
      stim_mem[i] = 8'($urandom);
      exp_mem[i] = stim_mem[i];
      if ($urandom_range(0, 99) < bad_pct)
        exp_mem[i] = stim_mem[i] ^ 8'(1 + $urandom_range(0, 254));
    end
  endtask

  task automatic set_hold(input int pct);
    for (int k = 0; k < HP; k++)
      hold_pat[k] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic run_seq(input int n, input string tag);
    int ex_rd[$];
    int rd_c[$];
    int rd_a[$];
    int ct_c[$];
    int dv[$];
    int iss;
    int nbad;
    int done_c;
    int ex_done;
    logic pass_v;
    logic [15:0] bm;
    logic [15:0] bx;
    logic [15:0] dm;
    logic [15:0] dx;

    iss = 0;
    for (int k = 1; k < HP && iss < n; k++)
      if (!hold_pat[k]) begin
        ex_rd.push_back(k);
        iss++;
      end
    nbad = 0;
    for (int i = 0; i < n; i++)
      if (exp_mem[i] != stim_mem[i])
        nbad++;
    ex_done = (n == 0) ? 2 : ex_rd[ex_rd.size()-1] + 7 + LAT;

    bm = match_c;
    bx = miss_c;
    done_c = -1;
    pass_v = 1'b0;
    for (int k = 0; k < 4000 && done_c < 0; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      num_vec = 8'(n);
      hold = (k < HP) ? hold_pat[k] : 1'b0;
      @(negedge clk);
      if (mem_rd) begin
        rd_c.push_back(k);
        rd_a.push_back(int'(mem_addr));
      end
      if (dut_in_valid)
        dv.push_back(int'(dut_in_vec));
      if (ctrans)
        ct_c.push_back(k);
      if (done) begin
        done_c = k;
        pass_v = pass;
      end
    end
    hold = 1'b0;
    dm = match_c - bm;
    dx = miss_c - bx;

    chk({tag, ":rd_n"}, rd_c.size(), n);
    chk({tag, ":ct_n"}, ct_c.size(), n);
    chk({tag, ":dv_n"}, dv.size(), n);
    for (int i = 0; i < n && i < rd_c.size() && i < ex_rd.size(); i++) begin
      chk({tag, ":rd_cyc"}, rd_c[i], ex_rd[i]);
      chk({tag, ":rd_addr"}, rd_a[i], i);
    end
    for (int i = 0; i < n && i < ct_c.size() && i < ex_rd.size(); i++)
      chk({tag, ":ct_cyc"}, ct_c[i], ex_rd[i] + 1 + LAT);
    for (int i = 0; i < n && i < dv.size(); i++)
      chk({tag, ":stim"}, dv[i], int'(stim_mem[i]));
    chk({tag, ":done_cyc"}, done_c, ex_done);
    chk({tag, ":pass"}, pass_v, (nbad == 0));
    chk({tag, ":dmatch"}, dm, 16'(n - nbad));
    chk({tag, ":dmiss"}, dx, 16'(nbad));

    @(negedge clk);
    chk({tag, ":done_1cyc"}, done, 1'b0);
    chk({tag, ":idle"}, busy, 1'b0);
    chk({tag, ":pass_hold"}, pass, (nbad == 0));
  endtask

  int nd;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_vec = '0;
    hold = 1'b0;
    set_hold(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {mem_rd, mem_addr, dut_in_valid, dut_in_vec,
                       cmp_on, ctrans, exp_vec_out, busy, done, pass}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    preload(16'h0000);

    load_mem(4, 0);
    run_seq(4, "basic");

    load_mem(4, 0);
    exp_mem[2] = stim_mem[2] ^ 8'h5a;
    run_seq(4, "bad2");

    load_mem(4, 0);
    set_hold(0);
    hold_pat[3] = 1'b1;
    hold_pat[4] = 1'b1;
    hold_pat[5] = 1'b1;
    run_seq(4, "hold");
    set_hold(0);

    run_seq(0, "zero");

    preload(16'hfffe);
    load_mem(4, 0);
    run_seq(4, "wrap");

    // abort mid-run after two issues
    load_mem(6, 0);
    @(posedge clk); #1;
    start = 1'b1;
    num_vec = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_rd", mem_rd, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {mem_rd, mem_addr, dut_in_valid, dut_in_vec,
                     cmp_on, ctrans, exp_vec_out, busy, done, pass}, 0);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy)
        nd++;
    end
    chk("rst_quiet", nd, 0);
    load_mem(6, 0);
    run_seq(6, "after_rst");

    load_mem(255, 0);
    run_seq(255, "full");

    for (int r = 0; r < 12; r++) begin
      if (r % 4 == 3)
        preload(16'hfff0 + 16'($urandom_range(0, 15)));
      load_mem(256, (r % 3 == 0) ? 20 : 0);
      set_hold($urandom_range(0, 40));
      run_seq($urandom_range(0, 40), "rand");
    end
    set_hold(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
